// File: rtl/code_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : code_sel_arbiter
// Description : Round-robin scheduler sharing one combinational code-word
//               datapath among NREQ requesters. The winning request's select
//               code and operands are registered onto the datapath for one
//               cycle, the datapath result is registered, and it is returned
//               with the requester ID over a valid/ready response channel.
// Ports       : sysclk/reset       clock, synchronous active-high reset
//               req_valid/ready    per-requester request handshake (one-hot)
//               req_sel/a/b        flat per-requester select code and operands
//               dp_sel/a/b         registered datapath inputs
//               dp_code            combinational datapath result
//               rsp_valid/ready    response handshake
//               rsp_id/rsp_code    response requester index and result
//               busy               high whenever an operation is in flight
//               ops_done           completed-response counter (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module code_sel_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3,
  parameter int ID_W   = 2
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*SEL_W-1:0]  req_sel,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  output logic [NREQ-1:0]        req_ready,
  output logic [SEL_W-1:0]       dp_sel,
  output logic [DATA_W-1:0]      dp_a,
  output logic [DATA_W-1:0]      dp_b,
  input  logic [DATA_W-1:0]      dp_code,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [DATA_W-1:0]      rsp_code,
  input  logic                   rsp_ready,
  output logic                   busy,
  output logic [15:0]            ops_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [SEL_W-1:0]    r_dp_sel;
  logic [DATA_W-1:0]   r_dp_a;
  logic [DATA_W-1:0]   r_dp_b;
  logic                r_rsp_valid;
  logic [ID_W-1:0]     r_rsp_id;
  logic [DATA_W-1:0]   r_rsp_code;
  logic [15:0]         r_ops_done;

  logic                w_any;
  logic [ID_W-1:0]     w_grant;
  logic                w_accept;
  logic                w_handshake;
  logic [NREQ-1:0]     w_req_ready;

  // Round-robin search starting at r_rr_ptr. Scanning offsets from the far
  // end down to zero lets the closest valid requester overwrite the others.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
        w_any   = 1'b1;
        w_grant = ID_W'((int'(r_rr_ptr) + k) % NREQ);
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_handshake  = 1'b0;
    w_req_ready  = '0;
    case (r_state)
      S_IDLE: begin
        // Reset gating keeps a request from looking accepted while the
        // block is being held in reset.
        if (w_any && !reset) begin
          w_accept     = 1'b1;
          w_req_ready  = NREQ'(1) << w_grant;
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        w_next_state = S_RESP;
      end
      S_RESP: begin
        if (r_rsp_valid && rsp_ready) begin
          w_handshake  = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_dp_sel    <= '0;
      r_dp_a      <= '0;
      r_dp_b      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_code  <= '0;
      r_ops_done  <= '0;
    end else begin
      if (w_accept) begin
        r_dp_sel <= req_sel[w_grant*SEL_W +: SEL_W];
        r_dp_a   <= req_a[w_grant*DATA_W +: DATA_W];
        r_dp_b   <= req_b[w_grant*DATA_W +: DATA_W];
        r_rsp_id <= w_grant;
      end
      if (r_state == S_EXEC) begin
        r_rsp_code  <= dp_code;
        r_rsp_valid <= 1'b1;
      end
      // r_rsp_id still holds the served requester, so it drives the
      // pointer update: the last-served requester drops to lowest priority.
      if (w_handshake) begin
        r_rsp_valid <= 1'b0;
        r_ops_done  <= r_ops_done + 16'd1;
        r_rr_ptr    <= ID_W'((int'(r_rsp_id) + 1) % NREQ);
      end
    end
  end

  assign req_ready = w_req_ready;
  assign dp_sel    = r_dp_sel;
  assign dp_a      = r_dp_a;
  assign dp_b      = r_dp_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_code  = r_rsp_code;
  assign busy      = (r_state != S_IDLE);
  assign ops_done  = r_ops_done;

endmodule
`default_nettype wire

// File: tb/tb_code_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_code_sel_arbiter
// Description : Directed self-checking bench for code_sel_arbiter. Provides a
//               small combinational datapath model driven by dp_sel/dp_a/dp_b.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_code_sel_arbiter;

  localparam int NREQ   = 4;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;
  localparam int ID_W   = 2;

  logic                   sysclk;
  logic                   reset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*SEL_W-1:0]  req_sel;
  logic [NREQ*DATA_W-1:0] req_a;
  logic [NREQ*DATA_W-1:0] req_b;
  logic [NREQ-1:0]        req_ready;
  logic [SEL_W-1:0]       dp_sel;
  logic [DATA_W-1:0]      dp_a;
  logic [DATA_W-1:0]      dp_b;
  logic [DATA_W-1:0]      dp_code;
  logic                   rsp_valid;
  logic [ID_W-1:0]        rsp_id;
  logic [DATA_W-1:0]      rsp_code;
  logic                   rsp_ready;
  logic                   busy;
  logic [15:0]            ops_done;

  int n_tests;
  int n_fail;

  code_sel_arbiter #(
    .NREQ(NREQ), .DATA_W(DATA_W), .SEL_W(SEL_W), .ID_W(ID_W)
  ) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_sel   (req_sel),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .dp_sel    (dp_sel),
    .dp_a      (dp_a),
    .dp_b      (dp_b),
    .dp_code   (dp_code),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_code  (rsp_code),
    .rsp_ready (rsp_ready),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Datapath model: 010 -> FF, 011 -> 00, 101 -> a^b, otherwise a+b (wraps).
  always_comb begin
    case (dp_sel)
      3'b010:  dp_code = 8'hFF;
      3'b011:  dp_code = 8'h00;
      3'b101:  dp_code = dp_a ^ dp_b;
      default: dp_code = dp_a + dp_b;
    endcase
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] sel, input logic [7:0] a,
                         input logic [7:0] b);
    req_sel[i*SEL_W +: SEL_W] = sel;
    req_a[i*DATA_W +: DATA_W] = a;
    req_b[i*DATA_W +: DATA_W] = b;
  endtask

  // One full operation starting in IDLE with requests already presented.
  task automatic do_op(input string tag, input int id, input logic [7:0] code);
    logic [3:0] onehot;
    onehot = 4'b0001 << id;
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'(onehot));
    tick();
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    tick();
    chk({tag, "_rvalid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_rid"}, 32'(rsp_id), 32'(id));
    chk({tag, "_rcode"}, 32'(rsp_code), 32'(code));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_rdone"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    req_valid = '0;
    req_sel   = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset state
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_dp_sel", 32'(dp_sel), 32'd0);
    chk("rst_dp_a", 32'(dp_a), 32'd0);
    chk("rst_rvalid", 32'(rsp_valid), 32'd0);
    chk("rst_rcode", 32'(rsp_code), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ops", 32'(ops_done), 32'd0);

    // Single request on requester 0, sel 101: F0 ^ 12 = E2
    set_req(0, 3'b101, 8'hF0, 8'h12);
    req_valid = 4'b0001;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    chk("t1_ready_exec", 32'(req_ready), 32'h0);
    chk("t1_dp_sel", 32'(dp_sel), 32'h5);
    chk("t1_dp_a", 32'(dp_a), 32'hF0);
    chk("t1_dp_b", 32'(dp_b), 32'h12);
    chk("t1_rvalid_exec", 32'(rsp_valid), 32'd0);
    tick();
    chk("t1_rvalid", 32'(rsp_valid), 32'd1);
    chk("t1_rid", 32'(rsp_id), 32'd0);
    chk("t1_rcode", 32'(rsp_code), 32'hE2);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t1_ops", 32'(ops_done), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);

    // Fresh reset, then all four valid: grants 0,1,2,3,0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 3'b010, 8'h11, 8'h22);
    set_req(1, 3'b011, 8'h33, 8'h44);
    set_req(2, 3'b000, 8'h01, 8'h02);
    set_req(3, 3'b101, 8'hAA, 8'h55);
    req_valid = 4'b1111;
    do_op("t2_op0", 0, 8'hFF);
    do_op("t2_op1", 1, 8'h00);
    do_op("t2_op2", 2, 8'h03);
    do_op("t2_op3", 3, 8'hFF);
    do_op("t2_op4", 0, 8'hFF);
    chk("t2_ops", 32'(ops_done), 32'd5);

    // Default select: wrapping add
    req_valid = 4'b0100;
    set_req(2, 3'b100, 8'hF0, 8'h20);
    do_op("t3_wrap", 2, 8'h10);
    set_req(2, 3'b100, 8'h03, 8'h04);
    do_op("t3_add", 2, 8'h07);
    chk("t3_ops", 32'(ops_done), 32'd7);

    // Back-pressure: response held for 10 cycles, no new grants
    req_valid = 4'b0010;
    set_req(1, 3'b000, 8'h05, 8'h06);
    #1;
    chk("t4_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b1111;
    tick();
    for (int c = 0; c < 10; c++) begin
      chk("t4_rvalid", 32'(rsp_valid), 32'd1);
      chk("t4_rid", 32'(rsp_id), 32'd1);
      chk("t4_rcode", 32'(rsp_code), 32'h0B);
      chk("t4_ready_hold", 32'(req_ready), 32'd0);
      chk("t4_busy", 32'(busy), 32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t4_ops", 32'(ops_done), 32'd8);

    // Reset during EXEC: pointer was 2, must return to 0
    req_valid = 4'b0001;
    #1;
    chk("t5_ready", 32'(req_ready), 32'h1);
    tick();
    chk("t5_busy_exec", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_rvalid", 32'(rsp_valid), 32'd0);
    chk("t5_ops", 32'(ops_done), 32'd0);
    chk("t5_rrptr", 32'(req_ready), 32'h1);
    chk("t5_dp_sel", 32'(dp_sel), 32'd0);
    req_valid = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t5_no_stale", 32'(rsp_valid), 32'd0);
    end

    // Counter wrap from FFFF
    force dut.r_ops_done = 16'hFFFF;
    #1;
    release dut.r_ops_done;
    #1;
    chk("t6_pre", 32'(ops_done), 32'hFFFF);
    req_valid = 4'b1000;
    set_req(3, 3'b011, 8'h12, 8'h34);
    do_op("t6_op", 3, 8'h00);
    chk("t6_wrap", 32'(ops_done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
